multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller.sv | 206 ++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multicycle CPU control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with memory-wait timeout,
// sticky error state and a retired-instruction counter.
module multicycle_controller #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] ir,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        reg_we,
  output logic [1:0]  reg_dst,
  output logic [1:0]  wb_src,
  output logic        alu_srcA,
  output logic [1:0]  alu_srcB,
  output logic [2:0]  alu_op,
  output logic [2:0]  state,
  output logic        err,
  output logic [15:0] retired
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StErr    = 3'd5
  } state_e;

  localparam logic [3:0] TimeoutCnt = 4'(TIMEOUT);

  state_e      state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic        err_q, err_d;
  logic [15:0] retired_q, retired_d;

  logic [5:0] opcode, funct;
  logic is_add, is_sub, is_slt, is_jr, is_lw, is_sw, is_addi, is_xori, is_bne, is_j, is_jal;
  logic is_rtype, is_alu_r, waiting;

  assign opcode   = ir[31:26];
  assign funct    = ir[5:0];
  assign is_rtype = (opcode == 6'h00);
  assign is_add   = is_rtype && (funct == 6'h20);
  assign is_sub   = is_rtype && (funct == 6'h22);
  assign is_slt   = is_rtype && (funct == 6'h2A);
  assign is_jr    = is_rtype && (funct == 6'h08);
  assign is_alu_r = is_add || is_sub || is_slt;
  assign is_lw    = (opcode == 6'h23);
  assign is_sw    = (opcode == 6'h2B);
  assign is_addi  = (opcode == 6'h08);
  assign is_xori  = (opcode == 6'h0E);
  assign is_bne   = (opcode == 6'h05);
  assign is_j     = (opcode == 6'h02);
  assign is_jal   = (opcode == 6'h03);

  assign waiting = ((state_q == StFetch) || (state_q == StMem)) && !mem_ready;

  always_comb begin
    state_d  = state_q;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    iord     = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_src   = 2'd0;
    reg_we   = 1'b0;
    reg_dst  = 2'd0;
    wb_src   = 2'd0;
    alu_srcA = 1'b0;
    alu_srcB = 2'd0;
    alu_op   = 3'd0;

    case (state_q)
      StFetch: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (is_alu_r || is_lw || is_sw || is_addi || is_xori || is_bne) begin
          state_d = StExec;
        end else if (is_jr) begin
          pc_we   = 1'b1;
          pc_src  = 2'd3;
          state_d = StFetch;
        end else if (is_j) begin
          pc_we   = 1'b1;
          pc_src  = 2'd2;
          state_d = StFetch;
        end else if (is_jal) begin
          pc_we   = 1'b1;
          pc_src  = 2'd2;
          reg_we  = 1'b1;
          reg_dst = 2'd2;
          wb_src  = 2'd2;
          state_d = StFetch;
        end else begin
          state_d = StErr;
        end
      end
      StExec: begin
        if (is_alu_r) begin
          alu_srcA = 1'b1;
          alu_op   = is_sub ? 3'd1 : (is_slt ? 3'd3 : 3'd0);
          state_d  = StWb;
        end else if (is_addi) begin
          alu_srcA = 1'b1;
          alu_srcB = 2'd2;
          state_d  = StWb;
        end else if (is_xori) begin
          alu_srcA = 1'b1;
          alu_srcB = 2'd3;
          alu_op   = 3'd2;
          state_d  = StWb;
        end else if (is_lw || is_sw) begin
          alu_srcA = 1'b1;
          alu_srcB = 2'd2;
          state_d  = StMem;
        end else if (is_bne) begin
          alu_srcA = 1'b1;
          alu_op   = 3'd1;
          pc_src   = 2'd1;
          pc_we    = ~zero;
          state_d  = StFetch;
        end else begin
          // IR changed under us mid-instruction; nothing sensible to execute.
          state_d = StErr;
        end
      end
      StMem: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = is_sw;
        if (mem_ready) begin
          if (is_sw)      state_d = StFetch;
          else if (is_lw) state_d = StWb;
          else            state_d = StErr;
        end
      end
      StWb: begin
        if (is_alu_r) begin
          reg_we  = 1'b1;
          reg_dst = 2'd1;
          state_d = StFetch;
        end else if (is_addi || is_xori) begin
          reg_we  = 1'b1;
          state_d = StFetch;
        end else if (is_lw) begin
          reg_we  = 1'b1;
          wb_src  = 2'd1;
          state_d = StFetch;
        end else begin
          state_d = StErr;
        end
      end
      StErr: state_d = StErr;
      default: state_d = StErr;
    endcase

    // Completion beats timeout: only an unanswered request can expire.
    if (waiting && (wait_q == TimeoutCnt)) state_d = StErr;
  end

  always_comb begin
    if (state_d != state_q) wait_d = 4'd0;
    else if (waiting)       wait_d = wait_q + 4'd1;
    else                    wait_d = wait_q;

    err_d = err_q || (state_d == StErr);

    retired_d = retired_q;
    if ((state_q inside {StDecode, StExec, StMem, StWb}) && (state_d == StFetch)) begin
      retired_d = retired_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StFetch;
      wait_q    <= 4'd0;
      err_q     <= 1'b0;
      retired_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      err_q     <= err_d;
      retired_q <= retired_d;
    end
  end

  assign state   = state_q;
  assign err     = err_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: expected output vectors are queued as each step is
// driven and popped for comparison once the DUT outputs settle.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] ir;
  logic        zero;
  logic        mem_ready;
  logic        mem_req, mem_we, iord, ir_we, pc_we, reg_we, alu_srcA, err;
  logic [1:0]  pc_src, reg_dst, wb_src, alu_srcB;
  logic [2:0]  alu_op, state;
  logic [15:0] retired;

  multicycle_controller #(.TIMEOUT(15)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ir        (ir),
    .zero      (zero),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .iord      (iord),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .pc_src    (pc_src),
    .reg_we    (reg_we),
    .reg_dst   (reg_dst),
    .wb_src    (wb_src),
    .alu_srcA  (alu_srcA),
    .alu_srcB  (alu_srcB),
    .alu_op    (alu_op),
    .state     (state),
    .err       (err),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] state;
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       reg_we;
    logic [1:0] reg_dst;
    logic [1:0] wb_src;
    logic       alu_srcA;
    logic [1:0] alu_srcB;
    logic [2:0] alu_op;
    logic       err;
  } outs_t;

  outs_t sb[$];
  int    n_chk  = 0;
  int    n_fail = 0;

  // Idle outputs of a state; memory states request, ERR flags err.
  function automatic outs_t base(input logic [2:0] st);
    outs_t o = '0;
    o.state   = st;
    o.mem_req = (st == 3'd0) || (st == 3'd3);
    o.iord    = (st == 3'd3);
    o.err     = (st == 3'd5);
    return o;
  endfunction

  function automatic outs_t f_fetch(input logic rdy);
    outs_t o = base(3'd0);
    o.ir_we = rdy;
    o.pc_we = rdy;
    return o;
  endfunction

  function automatic outs_t f_exec(input logic [1:0] srcb, input logic [2:0] op);
    outs_t o = base(3'd2);
    o.alu_srcA = 1'b1;
    o.alu_srcB = srcb;
    o.alu_op   = op;
    return o;
  endfunction

  function automatic outs_t f_wb(input logic [1:0] dst, input logic [1:0] src);
    outs_t o = base(3'd4);
    o.reg_we  = 1'b1;
    o.reg_dst = dst;
    o.wb_src  = src;
    return o;
  endfunction

  function automatic outs_t f_mem(input logic we);
    outs_t o = base(3'd3);
    o.mem_we = we;
    return o;
  endfunction

  function automatic outs_t f_dec_jump(input logic [1:0] src, input logic link);
    outs_t o = base(3'd1);
    o.pc_we  = 1'b1;
    o.pc_src = src;
    o.reg_we = link;
    o.reg_dst = link ? 2'd2 : 2'd0;
    o.wb_src  = link ? 2'd2 : 2'd0;
    return o;
  endfunction

  task automatic chk(input string tag);
    outs_t e, a;
    e = sb.pop_front();
    a = {state, mem_req, mem_we, iord, ir_we, pc_we, pc_src, reg_we, reg_dst, wb_src,
         alu_srcA, alu_srcB, alu_op, err};
    n_chk++;
    assert (a === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, a, e);
    end
  endtask

  task automatic chk_ret(input string tag, input logic [15:0] exp);
    n_chk++;
    assert (retired === exp) else begin
      n_fail++;
      $error("FAIL %s: observed retired %h expected %h", tag, retired, exp);
    end
  endtask

  // Drive one cycle's inputs, queue its expected outputs, compare, then advance a clock.
  task automatic step(input logic rdy, input logic z, input outs_t e, input string tag);
    mem_ready = rdy;
    zero      = z;
    sb.push_back(e);
    #1;
    chk(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    reset_n   = 1'b0;
    mem_ready = 1'b0;
    sb.push_back(f_fetch(1'b0));
    #1;
    chk(tag);
    chk_ret({tag, "_ret"}, 16'h0000);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; ir = 32'h0; zero = 1'b0; mem_ready = 1'b0;
    #2;
    do_reset("reset");

    // ADD: 0,1,2,4 then back to FETCH.
    ir = 32'h012A4020;
    step(1'b1, 1'b0, f_fetch(1'b1),           "add_fetch");
    step(1'b0, 1'b0, base(3'd1),              "add_dec");
    step(1'b0, 1'b0, f_exec(2'd0, 3'd0),      "add_exec");
    step(1'b0, 1'b0, f_wb(2'd1, 2'd0),        "add_wb");
    chk_ret("add_ret", 16'd1);

    // LW with three wait cycles in MEM: 8 cycles total.
    ir = 32'h8D090004;
    step(1'b1, 1'b0, f_fetch(1'b1),           "lw_fetch");
    step(1'b0, 1'b0, base(3'd1),              "lw_dec");
    step(1'b0, 1'b0, f_exec(2'd2, 3'd0),      "lw_exec");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, f_mem(1'b0), "lw_mem_wait");
    step(1'b1, 1'b0, f_mem(1'b0),             "lw_mem_done");
    step(1'b0, 1'b0, f_wb(2'd0, 2'd1),        "lw_wb");
    chk_ret("lw_ret", 16'd2);

    // BNE not taken then taken.
    ir = 32'h1509FFFE;
    begin
      outs_t e;
      step(1'b1, 1'b0, f_fetch(1'b1),         "bne0_fetch");
      step(1'b0, 1'b0, base(3'd1),            "bne0_dec");
      e = f_exec(2'd0, 3'd1); e.pc_src = 2'd1;
      step(1'b0, 1'b1, e,                     "bne_zero1_exec");
      chk_ret("bne0_ret", 16'd3);
      step(1'b1, 1'b0, f_fetch(1'b1),         "bne1_fetch");
      step(1'b0, 1'b0, base(3'd1),            "bne1_dec");
      e.pc_we = 1'b1;
      step(1'b0, 1'b0, e,                     "bne_zero0_exec");
      chk_ret("bne1_ret", 16'd4);
    end

    // JAL retires from DECODE.
    ir = 32'h0C000010;
    step(1'b1, 1'b0, f_fetch(1'b1),           "jal_fetch");
    step(1'b0, 1'b0, f_dec_jump(2'd2, 1'b1),  "jal_dec");
    chk_ret("jal_ret", 16'd5);

    // SW completes from MEM.
    ir = 32'hAD090008;
    step(1'b1, 1'b0, f_fetch(1'b1),           "sw_fetch");
    step(1'b0, 1'b0, base(3'd1),              "sw_dec");
    step(1'b0, 1'b0, f_exec(2'd2, 3'd0),      "sw_exec");
    step(1'b1, 1'b0, f_mem(1'b1),             "sw_mem");
    chk_ret("sw_ret", 16'd6);

    ir = 32'h392900FF;
    step(1'b1, 1'b0, f_fetch(1'b1),           "xori_fetch");
    step(1'b0, 1'b0, base(3'd1),              "xori_dec");
    step(1'b0, 1'b0, f_exec(2'd3, 3'd2),      "xori_exec");
    step(1'b0, 1'b0, f_wb(2'd0, 2'd0),        "xori_wb");
    chk_ret("xori_ret", 16'd7);

    ir = 32'h012A402A;
    step(1'b1, 1'b0, f_fetch(1'b1),           "slt_fetch");
    step(1'b0, 1'b0, base(3'd1),              "slt_dec");
    step(1'b0, 1'b0, f_exec(2'd0, 3'd3),      "slt_exec");
    step(1'b0, 1'b0, f_wb(2'd1, 2'd0),        "slt_wb");
    chk_ret("slt_ret", 16'd8);

    ir = 32'h03E00008;
    step(1'b1, 1'b0, f_fetch(1'b1),           "jr_fetch");
    step(1'b0, 1'b0, f_dec_jump(2'd3, 1'b0),  "jr_dec");
    chk_ret("jr_ret", 16'd9);

    // Reset in the middle of a SW memory wait aborts it.
    ir = 32'hAD090008;
    step(1'b1, 1'b0, f_fetch(1'b1),           "swr_fetch");
    step(1'b0, 1'b0, base(3'd1),              "swr_dec");
    step(1'b0, 1'b0, f_exec(2'd2, 3'd0),      "swr_exec");
    step(1'b0, 1'b0, f_mem(1'b1),             "swr_mem");
    do_reset("swr_reset");
    step(1'b1, 1'b0, f_fetch(1'b1),           "swr_post_fetch");
    step(1'b0, 1'b0, base(3'd1),              "swr_post_dec");
    do_reset("reset2");

    // FETCH timeout: 16 waiting cycles, then ERR regardless of mem_ready.
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, f_fetch(1'b0), "to_fetch_wait");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, base(3'd5), "to_err_hold");
    chk_ret("to_ret", 16'd0);
    do_reset("reset3");

    // Undefined opcode goes straight to ERR.
    ir = 32'hFC000000;
    step(1'b1, 1'b0, f_fetch(1'b1),           "bad_fetch");
    step(1'b0, 1'b0, base(3'd1),              "bad_dec");
    step(1'b1, 1'b0, base(3'd5),              "bad_err");
    do_reset("reset4");

    // Preload the counter to its top value, then one J must wrap it.
    force dut.retired_q = 16'hFFFF;
    #1;
    release dut.retired_q;
    ir = 32'h08000004;
    step(1'b1, 1'b0, f_fetch(1'b1),           "wrap_fetch");
    step(1'b0, 1'b0, f_dec_jump(2'd2, 1'b0),  "wrap_dec");
    chk_ret("wrap_ret", 16'h0000);
    step(1'b0, 1'b0, f_fetch(1'b0),           "wrap_next_fetch");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
